snoop_initiator: RTL and testbench

- Initiator end of the ACE snoop channel: issues one AC snoop per upstream request, collects the CR response and any CD data beats, and returns the merged result upstream.
- Sits on the interconnect/CCU side, facing one cache's snoop responder port.
- Single outstanding snoop; requests are serialised.

---
 rtl/snoop_initiator.sv | 198 +++++++++++++++++++
 tb/tb_snoop_initiator.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_initiator.sv
// ----------------------------------------------------------------------------
// snoop_initiator
//   Initiator side of the ACE snoop channel. Accepts one upstream snoop
//   request at a time, issues it on AC, collects the CR response and any CD
//   data beats, then presents the merged result upstream until consumed.
//
//   Optional build macro: SNOOP_INIT_TIMEOUT_EN
//     When defined, a CR/CD wait counter aborts a snoop after TimeoutCycles
//     idle cycles and reports it as an error. When undefined the block waits
//     forever and the counter does not exist.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 upstream request (valid/ready, line address, type)
//   ac_*                  AC snoop address channel (to cache)
//   cr_*                  CR snoop response channel (from cache)
//   cd_*                  CD snoop data channel (from cache)
//   rsp_*                 upstream result (flags, line data, error)
//   busy_o                a snoop is in flight (state != IDLE)
// ----------------------------------------------------------------------------
module snoop_initiator #(
    parameter int AddrWidth     = 64,
    parameter int DataWidth     = 64,
    parameter int BeatsPerLine  = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AddrWidth-1:0]              req_addr_i,
    input  logic [3:0]                        req_snoop_i,
    output logic                              ac_valid_o,
    input  logic                              ac_ready_i,
    output logic [AddrWidth-1:0]              ac_addr_o,
    output logic [3:0]                        ac_snoop_o,
    input  logic                              cr_valid_i,
    output logic                              cr_ready_o,
    input  logic [4:0]                        cr_resp_i,
    input  logic                              cd_valid_i,
    output logic                              cd_ready_o,
    input  logic [DataWidth-1:0]              cd_data_i,
    input  logic                              cd_last_i,
    output logic                              rsp_valid_o,
    input  logic                              rsp_ready_i,
    output logic [4:0]                        rsp_flags_o,
    output logic [BeatsPerLine*DataWidth-1:0] rsp_data_o,
    output logic                              rsp_err_o,
    output logic                              busy_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_AC  = 3'd1;
    localparam logic [2:0] WAIT_CR  = 3'd2;
    localparam logic [2:0] RECV_CD  = 3'd3;
    localparam logic [2:0] SEND_RSP = 3'd4;

    localparam int              CntW     = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(BeatsPerLine - 1);

    // CR response bit positions: {wasUnique, isShared, passDirty, error, dataTransfer}
    localparam int FlagXfer = 0;
    localparam int FlagErr  = 1;

    logic [2:0]                        state;
    logic [AddrWidth-1:0]              addr_q;
    logic [3:0]                        snoop_q;
    logic [4:0]                        flags_q;
    logic [BeatsPerLine*DataWidth-1:0] data_q;
    logic                              err_q;
    logic [CntW-1:0]                   beat_cnt;
    logic                              legal;
    logic                              timeout;

    always_comb begin
        legal = (req_snoop_i == 4'b0000) || (req_snoop_i == 4'b0001) ||
                (req_snoop_i == 4'b0111) || (req_snoop_i == 4'b1001);
    end

`ifdef SNOOP_INIT_TIMEOUT_EN
    localparam int TmoW = $clog2(TimeoutCycles + 1);

    logic [TmoW-1:0] tmo_cnt;
    logic            cr_hs;
    logic            cd_hs;
    logic            waiting;

    assign cr_hs   = (state == WAIT_CR) && cr_valid_i;
    assign cd_hs   = (state == RECV_CD) && cd_valid_i;
    assign waiting = (state == WAIT_CR) || (state == RECV_CD);

    // The counter holds the number of cycles since the last handshake
    // (AC, CR or CD), the handshake cycle itself counting as one. A
    // handshake in the same cycle as expiry wins over the timeout.
    assign timeout = waiting && !cr_hs && !cd_hs &&
                     (tmo_cnt >= TmoW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (((state == SEND_AC) && ac_ready_i) || cr_hs || cd_hs) begin
            tmo_cnt <= TmoW'(1);
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            addr_q   <= '0;
            snoop_q  <= '0;
            flags_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q   <= req_addr_i;
                        snoop_q  <= req_snoop_i;
                        flags_q  <= '0;
                        data_q   <= '0;
                        beat_cnt <= '0;
                        if (legal) begin
                            err_q <= 1'b0;
                            state <= SEND_AC;
                        end else begin
                            // Unsupported snoop type: answer directly, never touch AC.
                            err_q <= 1'b1;
                            state <= SEND_RSP;
                        end
                    end
                end
                SEND_AC: begin
                    if (ac_ready_i) state <= WAIT_CR;
                end
                WAIT_CR: begin
                    if (cr_valid_i) begin
                        flags_q  <= cr_resp_i;
                        err_q    <= cr_resp_i[FlagErr];
                        beat_cnt <= '0;
                        // An erroring responder sends no data even if it claims to.
                        if (cr_resp_i[FlagXfer] && !cr_resp_i[FlagErr]) state <= RECV_CD;
                        else                                            state <= SEND_RSP;
                    end else if (timeout) begin
                        flags_q[FlagErr] <= 1'b1;
                        err_q            <= 1'b1;
                        state            <= SEND_RSP;
                    end
                end
                RECV_CD: begin
                    if (cd_valid_i) begin
                        for (int i = 0; i < BeatsPerLine; i++) begin
                            if (beat_cnt == CntW'(i)) data_q[i*DataWidth +: DataWidth] <= cd_data_i;
                        end
                        if (beat_cnt == LastBeat) begin
                            // Final slot: the beat must carry last, otherwise the
                            // burst is malformed; either way the line is complete.
                            if (!cd_last_i) err_q <= 1'b1;
                            state <= SEND_RSP;
                        end else if (cd_last_i) begin
                            err_q <= 1'b1;
                            state <= SEND_RSP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (timeout) begin
                        flags_q[FlagErr] <= 1'b1;
                        err_q            <= 1'b1;
                        state            <= SEND_RSP;
                    end
                end
                SEND_RSP: begin
                    if (rsp_ready_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (state == IDLE);
    assign ac_valid_o  = (state == SEND_AC);
    assign ac_addr_o   = addr_q;
    assign ac_snoop_o  = snoop_q;
    assign cr_ready_o  = (state == WAIT_CR);
    assign cd_ready_o  = (state == RECV_CD);
    assign rsp_valid_o = (state == SEND_RSP);
    assign rsp_flags_o = flags_q;
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_snoop_initiator.sv
// ----------------------------------------------------------------------------
// tb_snoop_initiator
//   Directed bench for snoop_initiator. A bench-side cache responder answers
//   AC/CR/CD according to per-test settings; a transaction-level model
//   derives the expected result from the request type and the responder's
//   behaviour, and a negedge monitor checks protocol rules every cycle.
// ----------------------------------------------------------------------------
module tb_snoop_initiator;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BEATS = 2;
    localparam int LW    = BEATS * DW;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i = '0;
    logic [3:0]    req_snoop_i = '0;
    logic          ac_valid_o;
    logic          ac_ready_i = 1'b0;
    logic [AW-1:0] ac_addr_o;
    logic [3:0]    ac_snoop_o;
    logic          cr_valid_i = 1'b0;
    logic          cr_ready_o;
    logic [4:0]    cr_resp_i = '0;
    logic          cd_valid_i = 1'b0;
    logic          cd_ready_o;
    logic [DW-1:0] cd_data_i = '0;
    logic          cd_last_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [4:0]    rsp_flags_o;
    logic [LW-1:0] rsp_data_o;
    logic          rsp_err_o;
    logic          busy_o;

    snoop_initiator #(
        .AddrWidth(AW), .DataWidth(DW), .BeatsPerLine(BEATS), .TimeoutCycles(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_snoop_i(req_snoop_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i),
        .ac_addr_o(ac_addr_o), .ac_snoop_o(ac_snoop_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o),
        .cd_data_i(cd_data_i), .cd_last_i(cd_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_flags_o(rsp_flags_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // responder settings
    int          p_ac_wait = 0;
    bit          p_cr_send = 1'b1;
    logic [4:0]  p_cr = '0;
    int          p_nbeats = 0;
    logic [63:0] p_data [4];
    logic        p_last [4];

    // expected result of the current transaction
    logic [AW-1:0] exp_addr = '0;
    logic [3:0]    exp_snoop = '0;
    logic [4:0]    exp_flags = '0;
    logic [LW-1:0] exp_data = '0;
    logic          exp_err = 1'b0;

    // monitor observations
    bit in_txn = 1'b0;
    int acc_cyc = 0, ac_hs_cyc = 0, cr_hs_cyc = 0, rsp_cyc = 0;
    int ac_hs = 0, cd_rdy_cnt = 0;
    logic [4:0]    got_flags;
    logic [LW-1:0] got_data;
    logic          got_err;
    bit            got;

    // Result the specification demands for a request given how the
    // responder will behave.
    function automatic void model(input logic [3:0] s, input logic [4:0] cr, input bit to);
        exp_flags = '0;
        exp_data  = '0;
        exp_err   = 1'b0;
        if (!(s inside {4'b0000, 4'b0001, 4'b0111, 4'b1001})) begin
            exp_err = 1'b1;
            return;
        end
        if (to) begin
            exp_flags = 5'b00010;
            exp_err   = 1'b1;
            return;
        end
        exp_flags = cr;
        exp_err   = cr[1];
        if (cr[0] && !cr[1]) begin
            for (int i = 0; i < BEATS; i++) begin
                exp_data[i*DW +: DW] = p_data[i];
                if (p_last[i] || i == BEATS - 1) begin
                    if (!(p_last[i] && i == BEATS - 1)) exp_err = 1'b1;
                    break;
                end
            end
        end
    endfunction

    // Cache-side responder.
    initial begin : responder
        forever begin
            @(posedge clk_i); #1;
            if (ac_valid_o && !rst_i) begin
                for (int w = 0; w < p_ac_wait; w++) begin
                    @(posedge clk_i); #1;
                end
                ac_ready_i = 1'b1;
                @(posedge clk_i); #1;
                ac_ready_i = 1'b0;
                if (p_cr_send) begin
                    cr_valid_i = 1'b1;
                    cr_resp_i  = p_cr;
                    @(posedge clk_i); #1;
                    cr_valid_i = 1'b0;
                    cr_resp_i  = '0;
                    for (int b = 0; b < p_nbeats; b++) begin
                        cd_valid_i = 1'b1;
                        cd_data_i  = p_data[b];
                        cd_last_i  = p_last[b];
                        @(posedge clk_i); #1;
                    end
                    cd_valid_i = 1'b0;
                    cd_last_i  = 1'b0;
                    cd_data_i  = '0;
                end
            end
        end
    end

    // Per-cycle protocol monitor.
    logic          prev_ac_stall = 1'b0, prev_rsp_stall = 1'b0;
    logic [AW-1:0] prev_ac_addr;
    logic [3:0]    prev_ac_snoop;
    logic [4:0]    prev_flags;
    logic [LW-1:0] prev_data;
    logic          prev_err;

    always @(negedge clk_i) begin
        if (rst_i) begin
            in_txn         = 1'b0;
            prev_ac_stall  = 1'b0;
            prev_rsp_stall = 1'b0;
        end else begin
            chk("req_ready_vs_txn", req_ready_o, !in_txn);
            chk("busy_vs_txn", busy_o, in_txn);
            chk("cr_cd_ready_exclusive", cr_ready_o & cd_ready_o, 1'b0);
            if (ac_valid_o) begin
                chk("ac_addr", ac_addr_o, exp_addr);
                chk("ac_snoop", ac_snoop_o, exp_snoop);
            end
            if (prev_ac_stall) begin
                chk("ac_valid_held", ac_valid_o, 1'b1);
                chk("ac_addr_stable", ac_addr_o, prev_ac_addr);
                chk("ac_snoop_stable", ac_snoop_o, prev_ac_snoop);
            end
            if (prev_rsp_stall) begin
                chk("rsp_valid_held", rsp_valid_o, 1'b1);
                chk("rsp_flags_stable", rsp_flags_o, prev_flags);
                chk("rsp_data_stable", rsp_data_o, prev_data);
                chk("rsp_err_stable", rsp_err_o, prev_err);
            end
            if (cd_ready_o) cd_rdy_cnt++;
            if (ac_valid_o && ac_ready_i) begin
                ac_hs++;
                ac_hs_cyc = cyc;
            end
            if (cr_valid_i && cr_ready_o) cr_hs_cyc = cyc;
            prev_ac_stall  = ac_valid_o && !ac_ready_i;
            prev_ac_addr   = ac_addr_o;
            prev_ac_snoop  = ac_snoop_o;
            prev_rsp_stall = rsp_valid_o && !rsp_ready_i;
            prev_flags     = rsp_flags_o;
            prev_data      = rsp_data_o;
            prev_err       = rsp_err_o;
            if (rsp_valid_o && rsp_ready_i) begin
                chk("rsp_flags", rsp_flags_o, exp_flags);
                chk("rsp_data", rsp_data_o, exp_data);
                chk("rsp_err", rsp_err_o, exp_err);
                in_txn = 1'b0;
            end
            if (req_valid_i && req_ready_o) begin
                acc_cyc = cyc;
                in_txn  = 1'b1;
            end
        end
    end

    task automatic run(input logic [AW-1:0] a, input logic [3:0] s, input int acw,
                       input bit crs, input logic [4:0] cr, input int nb,
                       input int rw, input bit to);
        p_ac_wait = acw;
        p_cr_send = crs;
        p_cr      = cr;
        p_nbeats  = nb;
        model(s, cr, to);
        exp_addr   = a;
        exp_snoop  = s;
        ac_hs      = 0;
        cd_rdy_cnt = 0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_snoop_i = s;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) got = 1'b1;
        end
        chk("rsp_arrives", got, 1'b1);
        rsp_cyc   = cyc;
        got_flags = rsp_flags_o;
        got_data  = rsp_data_o;
        got_err   = rsp_err_o;
        repeat (rw) @(negedge clk_i);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1'b1);
        chk({tag, "_ac_valid"}, ac_valid_o, 1'b0);
        chk({tag, "_ac_addr"}, ac_addr_o, '0);
        chk({tag, "_ac_snoop"}, ac_snoop_o, '0);
        chk({tag, "_cr_ready"}, cr_ready_o, 1'b0);
        chk({tag, "_cd_ready"}, cd_ready_o, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
        chk({tag, "_rsp_flags"}, rsp_flags_o, '0);
        chk({tag, "_rsp_data"}, rsp_data_o, '0);
        chk({tag, "_rsp_err"}, rsp_err_o, 1'b0);
        chk({tag, "_busy"}, busy_o, 1'b0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < 4; i++) begin
            p_data[i] = '0;
            p_last[i] = 1'b0;
        end
        @(negedge clk_i);
        chk_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ReadShared with two data beats, zero-wait partner
        p_data[0] = 64'h1111; p_last[0] = 1'b0;
        p_data[1] = 64'h2222; p_last[1] = 1'b1;
        run(64'h8000_1040, 4'b0001, 0, 1'b1, 5'b01001, 2, 0, 1'b0);
        chk("rs_latency", rsp_cyc - acc_cyc, 5);
        chk("rs_ac_count", ac_hs, 1);
        chk("rs_data_lit", got_data, {64'h2222, 64'h1111});
        chk("rs_flags_lit", got_flags, 5'b01001);
        chk("rs_err_lit", got_err, 1'b0);

        // CleanInvalid, no data
        run(64'h0000_2000, 4'b1001, 0, 1'b1, 5'b00000, 0, 0, 1'b0);
        chk("ci_no_cd_ready", cd_rdy_cnt, 0);
        chk("ci_rsp_after_cr", rsp_cyc - cr_hs_cyc, 1);
        chk("ci_data_lit", got_data, '0);

        // Illegal snoop type
        run(64'h0000_3000, 4'b0011, 0, 1'b1, 5'b00000, 0, 0, 1'b0);
        chk("ill_no_ac", ac_hs, 0);
        chk("ill_latency", rsp_cyc - acc_cyc, 1);
        chk("ill_err_lit", got_err, 1'b1);

        // ReadUnique with AC and response back-pressure
        run(64'hDEAD_BEE0, 4'b0111, 7, 1'b1, 5'b10100, 0, 3, 1'b0);
        chk("ru_ac_count", ac_hs, 1);
        chk("ru_flags_lit", got_flags, 5'b10100);
        chk("ru_err_lit", got_err, 1'b0);

        // ReadOnce, last on beat 0
        p_data[0] = 64'hAAAA_5555; p_last[0] = 1'b1;
        run(64'h0000_4040, 4'b0000, 0, 1'b1, 5'b00001, 1, 0, 1'b0);
        chk("early_err_lit", got_err, 1'b1);
        chk("early_data_lit", got_data, {64'h0, 64'hAAAA_5555});

        // Missing last on final beat
        p_data[0] = 64'hB0B0; p_last[0] = 1'b0;
        p_data[1] = 64'hB1B1; p_last[1] = 1'b0;
        run(64'h0000_5080, 4'b0001, 0, 1'b1, 5'b01001, 2, 1, 1'b0);
        chk("nolast_err_lit", got_err, 1'b1);
        chk("nolast_data_lit", got_data, {64'hB1B1, 64'hB0B0});

        // CR error with dataTransfer: no CD phase
        run(64'h0000_6000, 4'b0001, 0, 1'b1, 5'b00011, 0, 0, 1'b0);
        chk("crerr_no_cd_ready", cd_rdy_cnt, 0);
        chk("crerr_flags_lit", got_flags, 5'b00011);

`ifdef SNOOP_INIT_TIMEOUT_EN
        // No CR ever: abort after TimeoutCycles
        run(64'h0000_7000, 4'b0000, 0, 1'b0, 5'b00000, 0, 0, 1'b1);
        chk("tmo_latency", rsp_cyc - ac_hs_cyc, 16);
        chk("tmo_err_lit", got_err, 1'b1);
        chk("tmo_flags_lit", got_flags, 5'b00010);
`endif

        // Reset while receiving data
        p_ac_wait = 0; p_cr_send = 1'b1; p_cr = 5'b00001; p_nbeats = 1;
        p_data[0] = 64'hC0FFEE; p_last[0] = 1'b0;
        exp_addr = 64'h0000_8000; exp_snoop = 4'b0001;
        @(posedge clk_i); #1;
        req_valid_i = 1'b1; req_addr_i = 64'h0000_8000; req_snoop_i = 4'b0001;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk_i);
            if (cd_ready_o) got = 1'b1;
        end
        chk("reach_recv_cd", got, 1'b1);
        repeat (2) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_reset_outputs("midrst");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Normal operation after reset
        p_data[0] = 64'h3333; p_last[0] = 1'b0;
        p_data[1] = 64'h4444; p_last[1] = 1'b1;
        run(64'h0000_9040, 4'b0001, 1, 1'b1, 5'b01001, 2, 0, 1'b0);
        chk("post_rst_data_lit", got_data, {64'h4444, 64'h3333});
        chk("post_rst_ac_count", ac_hs, 1);

        repeat (3) @(negedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
